// File: rtl/apb_multi_slave_mem.sv
`default_nettype none
// apb_multi_slave_mem: APB4 completer with per-slave word memories, wait states, byte strobes and fault reporting.
// Rev 1.0
module apb_multi_slave_mem #(
  parameter int                      NO_OF_SLAVES      = 4,
  parameter int                      ADDRESS_WIDTH     = 32,
  parameter int                      DATA_WIDTH        = 32,
  parameter int                      SLAVE_MEMORY_SIZE = 16,
  parameter int                      SLAVE_MEMORY_GAP  = 2,
  parameter logic [NO_OF_SLAVES-1:0] SECURE_SLAVE_MASK = '0,
  parameter int                      CNT_WIDTH         = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NO_OF_SLAVES-1:0]   pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [4*NO_OF_SLAVES-1:0] wait_cfg,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      protocol_err,
  output logic [CNT_WIDTH-1:0]      wr_count,
  output logic [CNT_WIDTH-1:0]      rd_count,
  output logic [CNT_WIDTH-1:0]      err_count
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W      = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
  localparam int OFF_W      = (SLAVE_MEMORY_SIZE > 1) ? $clog2(SLAVE_MEMORY_SIZE) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] STRIDE = ADDRESS_WIDTH'(SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                   state, state_next;
  logic [DATA_WIDTH-1:0]    mem [NO_OF_SLAVES][SLAVE_MEMORY_SIZE];

  logic [IDX_W-1:0]         sel_idx;
  logic [3:0]               sel_wait;
  logic                     sel_onehot, addr_mapped, addr_unaligned, sel_secure, setup_err;
  logic [ADDRESS_WIDTH-1:0] word_idx, region_base, region_off;

  logic [IDX_W-1:0]         idx_q;
  logic [OFF_W-1:0]         off_q;
  logic                     wr_q, err_q;
  logic [DATA_WIDTH-1:0]    wdata_q, rbuf_q;
  logic [STRB_W-1:0]        strb_q;
  logic [3:0]               wait_q;
  logic                     setup, idle_violation, complete, abort;

  // Lowest selected bit picks the slave; a multi-bit select is flagged as an error anyway.
  always_comb begin
    sel_idx  = '0;
    sel_wait = '0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
      if (pselx[i]) begin
        sel_idx  = IDX_W'(i);
        sel_wait = wait_cfg[4*i +: 4];
      end
    end
  end

  assign sel_onehot     = (pselx != '0) && ((pselx & (pselx - NO_OF_SLAVES'(1))) == '0);
  assign word_idx       = paddr >> BYTE_SHIFT;
  assign region_base    = ADDRESS_WIDTH'(sel_idx) * STRIDE;
  assign region_off     = word_idx - region_base;
  assign addr_mapped    = (word_idx >= region_base) && (region_off < ADDRESS_WIDTH'(SLAVE_MEMORY_SIZE));
  assign addr_unaligned = (paddr & ADDRESS_WIDTH'(STRB_W - 1)) != '0;
  assign sel_secure     = SECURE_SLAVE_MASK[sel_idx] && pprot[1];
  assign setup_err      = !sel_onehot || !addr_mapped || addr_unaligned || sel_secure;

  // Only the non-secure bit of pprot affects the response.
  wire unused_prot = &{1'b0, pprot[2], pprot[0]};

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next     = state;
    setup          = 1'b0;
    idle_violation = 1'b0;
    complete       = 1'b0;
    abort          = 1'b0;
    case (state)
      IDLE: begin
        if (pselx != '0) begin
          if (!penable) begin
            setup      = 1'b1;
            state_next = ACCESS;
          end else begin
            idle_violation = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (pselx == '0) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (wait_q == 4'd0) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    pready  = complete;
    pslverr = complete && err_q;
    prdata  = (complete && !err_q && !wr_q) ? rbuf_q : '0;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx_q        <= '0;
      off_q        <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      strb_q       <= '0;
      wait_q       <= '0;
      protocol_err <= 1'b0;
      wr_count     <= '0;
      rd_count     <= '0;
      err_count    <= '0;
      for (int s = 0; s < NO_OF_SLAVES; s++) begin
        for (int w = 0; w < SLAVE_MEMORY_SIZE; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else begin
      protocol_err <= idle_violation || abort;
      if (setup) begin
        idx_q   <= sel_idx;
        off_q   <= region_off[OFF_W-1:0];
        wr_q    <= pwrite;
        err_q   <= setup_err;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        wait_q  <= sel_wait;
        rbuf_q  <= setup_err ? '0 : mem[sel_idx][region_off[OFF_W-1:0]];
      end else if (state == ACCESS && !abort && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (complete) begin
        if (err_q) begin
          if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
        end else if (wr_q) begin
          if (wr_count != '1) wr_count <= wr_count + CNT_WIDTH'(1);
          for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) mem[idx_q][off_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end else begin
          if (rd_count != '1) rd_count <= rd_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_slave_mem.sv
`default_nettype none
// tb_apb_multi_slave_mem: randomized APB traffic checked every cycle against a transaction-level memory model.
// Rev 1.0
module tb_apb_multi_slave_mem;

  localparam int         SIZE = 16;
  localparam int         GAP  = 2;
  localparam int         CW   = 5;
  localparam int         CMAX = (1 << CW) - 1;
  localparam logic [3:0] SEC  = 4'b0001;

  logic        clk = 1'b0;
  logic        preset_n;
  logic [3:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [15:0] wait_cfg;
  logic [31:0] prdata;
  logic        pready, pslverr, protocol_err;
  logic [CW-1:0] wr_count, rd_count, err_count;

  always #5 clk = ~clk;

  apb_multi_slave_mem #(
    .NO_OF_SLAVES(4), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_MEMORY_SIZE(SIZE), .SLAVE_MEMORY_GAP(GAP),
    .SECURE_SLAVE_MASK(SEC), .CNT_WIDTH(CW)
  ) dut (
    .pclk(clk), .preset_n(preset_n), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .wait_cfg(wait_cfg),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .protocol_err(protocol_err),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: sparse memory keyed by global word index, plus saturating counters.
  logic [31:0] mdl [longint];
  int          wr_m, rd_m, err_m;
  logic        exp_pready, exp_pslverr, exp_perr;
  logic [31:0] exp_prdata;
  logic        pend_perr, pend_commit, pc_err, pc_wr;
  longint      pc_w;
  logic [31:0] pc_wd;
  logic [3:0]  pc_strb;
  logic        chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int lowest(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    mdl.delete();
    wr_m = 0; rd_m = 0; err_m = 0;
    pend_perr = 1'b0; pend_commit = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0; exp_perr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready", {31'b0, pready}, {31'b0, exp_pready});
      chk("pslverr", {31'b0, pslverr}, {31'b0, exp_pslverr});
      chk("prdata", prdata, exp_prdata);
      chk("protocol_err", {31'b0, protocol_err}, {31'b0, exp_perr});
      chk("wr_count", 32'(wr_count), 32'(wr_m));
      chk("rd_count", 32'(rd_count), 32'(rd_m));
      chk("err_count", 32'(err_count), 32'(err_m));
    end
  end

  // Advance one clock: retire the transfer completed at this edge, then leave us 1ns past it.
  task automatic cycle();
    logic [31:0] v;
    @(posedge clk);
    if (pend_commit) begin
      pend_commit = 1'b0;
      if (pc_err) err_m = sat(err_m);
      else if (pc_wr) begin
        v = mdl.exists(pc_w) ? mdl[pc_w] : 32'h0;
        for (int b = 0; b < 4; b++) if (pc_strb[b]) v[8*b +: 8] = pc_wd[8*b +: 8];
        mdl[pc_w] = v;
        wr_m = sat(wr_m);
      end else rd_m = sat(rd_m);
    end
    exp_perr  = pend_perr;
    pend_perr = 1'b0;
    #1;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      pselx = '0; penable = 1'b0;
    end
  endtask

  task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                      input int drop_at, output logic [31:0] got_rd, output logic got_err,
                      output int got_lat);
    int          idx, n;
    longint      w, base;
    logic        err;
    logic [31:0] rd;
    cycle();
    idx  = lowest(sel);
    n    = int'(wait_cfg[4*idx +: 4]);
    w    = longint'(addr >> 2);
    base = longint'(idx * (SIZE + GAP));
    err  = ($countones(sel) != 1) || (w < base) || (w - base >= SIZE) ||
           (addr[1:0] != 2'b00) || (SEC[idx] && prot[1]);
    rd   = (err || !mdl.exists(w)) ? 32'h0 : mdl[w];
    pselx = sel; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb; pprot = prot;
    got_rd = '0; got_err = 1'b0; got_lat = 0;
    for (int k = 1; k <= n + 1; k++) begin
      cycle();
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      pstrb   = 4'($urandom);
      if (k == drop_at) begin
        pselx = '0; penable = 1'b0; pend_perr = 1'b1;
        @(negedge clk);
        return;
      end
      if (k == n + 1) begin
        exp_pready  = 1'b1;
        exp_pslverr = err;
        exp_prdata  = (!err && !wr) ? rd : 32'h0;
        pend_commit = 1'b1; pc_err = err; pc_wr = wr; pc_w = w; pc_wd = wd; pc_strb = strb;
      end
      @(negedge clk);
      if (pready === 1'b1 && got_lat == 0) got_lat = k;
      if (k == n + 1) begin
        got_rd  = prdata;
        got_err = pslverr;
      end
    end
  endtask

  initial begin
    logic [31:0] grd;
    logic        gerr;
    int          glat;
    chk_en = 1'b0;
    model_clear();
    pselx = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    wait_cfg = '0;
    preset_n = 1'b1;
    #1 preset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pready", {31'b0, pready}, 32'h0);
    chk("reset_pslverr", {31'b0, pslverr}, 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    chk("reset_protocol_err", {31'b0, protocol_err}, 32'h0);
    chk("reset_counters", {17'b0, wr_count, rd_count, err_count}, 32'h0);
    preset_n = 1'b1;
    chk_en = 1'b1;

    // Wait states on slave 2: pready on the 4th access cycle.
    wait_cfg = 16'h0300;
    xfer(4'b0100, 32'h90, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 0, grd, gerr, glat);
    chk("t2_latency", 32'(glat), 32'd4);
    idle(1);
    @(negedge clk);
    chk("t2_wr_count", 32'(wr_count), 32'd1);

    // Zero-wait write/read on slave 1.
    wait_cfg = 16'h0000;
    xfer(4'b0010, 32'h48, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 0, grd, gerr, glat);
    xfer(4'b0010, 32'h48, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t1_rdata", grd, 32'hDEADBEEF);
    chk("t1_pslverr", {31'b0, gerr}, 32'h0);
    chk("t1_latency", 32'(glat), 32'd1);

    // Byte strobes, back-to-back.
    xfer(4'b0001, 32'h04, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 0, grd, gerr, glat);
    xfer(4'b0001, 32'h04, 1'b1, 32'h11223344, 4'b0101, 3'b000, 0, grd, gerr, glat);
    xfer(4'b0001, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t3_strobe_rdata", grd, 32'hFF22FF44);

    // Decode faults: gap, unaligned, multi-select.
    xfer(4'b0010, 32'h88, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t4_gap_err", {31'b0, gerr}, 32'h1);
    chk("t4_gap_rdata", grd, 32'h0);
    xfer(4'b0010, 32'h4A, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t4_unaligned_err", {31'b0, gerr}, 32'h1);
    xfer(4'b0011, 32'h48, 1'b1, 32'h12345678, 4'hF, 3'b000, 0, grd, gerr, glat);
    chk("t4_multisel_err", {31'b0, gerr}, 32'h1);
    xfer(4'b0010, 32'h48, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t4_mem_unchanged", grd, 32'hDEADBEEF);
    chk("t4_err_count", 32'(err_count), 32'd3);

    // Secure-only slave 0.
    xfer(4'b0001, 32'h00, 1'b1, 32'h0BADF00D, 4'hF, 3'b010, 0, grd, gerr, glat);
    chk("t5_nonsecure_err", {31'b0, gerr}, 32'h1);
    xfer(4'b0001, 32'h00, 1'b1, 32'h0BADF00D, 4'hF, 3'b000, 0, grd, gerr, glat);
    chk("t5_secure_ok", {31'b0, gerr}, 32'h0);

    // Abort mid-wait, then an IDLE-phase penable violation.
    wait_cfg = 16'h5000;
    xfer(4'b1000, 32'hD8, 1'b1, 32'h55AA55AA, 4'hF, 3'b000, 3, grd, gerr, glat);
    idle(1);
    @(negedge clk);
    chk("t6_abort_pulse", {31'b0, protocol_err}, 32'h1);
    wait_cfg = 16'h0000;
    xfer(4'b1000, 32'hD8, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t6_abort_no_write", grd, 32'h0);
    cycle();
    pselx = 4'b0010; penable = 1'b1; pend_perr = 1'b1;
    idle(1);
    @(negedge clk);
    chk("t6_idle_violation", {31'b0, protocol_err}, 32'h1);

    // Reset in the middle of an access.
    wait_cfg = 16'h0500;
    cycle();
    pselx = 4'b0100; penable = 1'b0; paddr = 32'h90; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b000;
    cycle();
    penable = 1'b1;
    #2 preset_n = 1'b0;
    model_clear();
    #1;
    chk("t6_rst_pready", {31'b0, pready}, 32'h0);
    chk("t6_rst_counters", {17'b0, wr_count, rd_count, err_count}, 32'h0);
    cycle();
    pselx = '0; penable = 1'b0;
    #2 preset_n = 1'b1;
    wait_cfg = 16'h0000;
    xfer(4'b0010, 32'h48, 1'b0, 32'h0, 4'h0, 3'b000, 0, grd, gerr, glat);
    chk("t6_rst_mem_cleared", grd, 32'h0);

    // Randomized traffic; counters saturate along the way.
    for (int t = 0; t < 300; t++) begin
      int          r, off, n, drop;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [2:0]  prot;
      if ($urandom_range(0, 9) == 0) idle(1 + $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        cycle();
        pselx = 4'(4'b0001 << $urandom_range(0, 3)); penable = 1'b1; pend_perr = 1'b1;
      end
      r    = $urandom_range(0, 3);
      off  = $urandom_range(0, 17);
      addr = 32'((r * (SIZE + GAP) + off) * 4);
      if ($urandom_range(0, 15) == 0) addr = addr + 32'($urandom_range(1, 3));
      case ($urandom_range(0, 19))
        0:       sel = 4'($urandom_range(1, 15));
        1, 2:    sel = 4'(4'b0001 << $urandom_range(0, 3));
        default: sel = 4'(4'b0001 << r);
      endcase
      for (int s = 0; s < 4; s++)
        wait_cfg[4*s +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 2));
      n    = int'(wait_cfg[4*lowest(sel) +: 4]);
      drop = (n > 0 && $urandom_range(0, 14) == 0) ? $urandom_range(1, n) : 0;
      prot = 3'($urandom);
      if ($urandom_range(0, 3) != 0) prot[1] = 1'b0;
      xfer(sel, addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), prot, drop, grd, gerr, glat);
    end
    idle(3);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
